// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared parameter defaults and output buffer occupancy encoding
package fifo_stream_reader_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int PKT_LEN_DEF = 4;
   typedef enum logic [1:0] {OCC_0 = 2'd0, OCC_1 = 2'd1, OCC_2 = 2'd2} occ_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: framed valid/ready output stream
interface fifo_stream_reader_if #(parameter int WIDTH = 32);
   logic m_valid;
   logic m_ready;
   logic m_last;
   logic [WIDTH-1:0] m_data;
   modport master (output m_valid, m_data, m_last, input m_ready);
   modport slave (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// stream_skid_buf2: 2-entry in-order valid/ready buffer with registered head and full flag
module stream_skid_buf2
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);
   occ_t occ, occ_nxt;
   logic [WIDTH-1:0] tail, head_nxt, tail_nxt;
   logic pop, acc;
   assign full = occ == OCC_2;
   assign m_valid = occ != OCC_0;
   assign pop = m_valid & m_ready;
   assign acc = push & ~full;
   always_comb begin
      occ_nxt = occ;
      head_nxt = m_data;
      tail_nxt = tail;
      case (occ)
         OCC_0: if (acc) begin
            head_nxt = push_data;
            occ_nxt = OCC_1;
         end
         OCC_1: if (acc & pop) head_nxt = push_data;
         else if (acc) begin
            tail_nxt = push_data;
            occ_nxt = OCC_2;
         end
         else if (pop) occ_nxt = OCC_0;
         OCC_2: if (pop) begin
            head_nxt = tail;
            occ_nxt = OCC_1;
         end
         default: occ_nxt = OCC_0;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         occ <= OCC_0;
         m_data <= '0;
         tail <= '0;
      end else begin
         occ <= occ_nxt;
         m_data <= head_nxt;
         tail <= tail_nxt;
      end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead fifo into a framed valid/ready stream
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int PKT_LEN = PKT_LEN_DEF,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     data_out,
   output logic                 r_ready,
   fifo_stream_reader_if.master m,
   output logic [31:0]          tx_count,
   output logic                 busy
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);
   logic full, acc;
   logic [CNT_W-1:0] beat;
   // pop gated by reset so nothing is taken from the fifo while both are held in reset
   assign r_ready = reset & en & ~fifo_empty & ~full;
   assign acc = m.m_valid & m.m_ready;
   assign m.m_last = m.m_valid & (beat == LAST);
   assign busy = m.m_valid;
   stream_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (r_ready),
      .push_data (data_out),
      .full      (full),
      .m_valid   (m.m_valid),
      .m_ready   (m.m_ready),
      .m_data    (m.m_data)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         beat <= '0;
         tx_count <= '0;
      end else if (acc) begin
         beat <= (beat == LAST) ? '0 : beat + 1'b1;
         tx_count <= tx_count + 32'd1;
      end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: fifo model drives the reader; scoreboard checks the framed stream
module tb_fifo_stream_reader;
   localparam int PKT_LEN = 4;
   typedef struct {logic [31:0] d; logic l;} exp_t;
   logic clk, reset, en, fifo_empty, r_ready, busy;
   logic [31:0] data_out, tx_count;
   fifo_stream_reader_if #(.WIDTH(32)) s ();
   fifo_stream_reader #(.WIDTH(32), .PKT_LEN(PKT_LEN), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .fifo_empty (fifo_empty),
      .data_out   (data_out),
      .r_ready    (r_ready),
      .m          (s),
      .tx_count   (tx_count),
      .busy       (busy)
   );
   int checks = 0, errors = 0;
   int n_pop = 0, n_del = 0, n_rr = 0;
   logic in_rst = 1, stalled = 0, prev_last;
   logic [31:0] prev_data;
   logic [31:0] fifo_q[$];
   exp_t exp_q[$];

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
      end
   endtask

   // one clock of stimulus; the fifo model pops when r_ready is seen before the edge
   task automatic step(input logic e, input logic mr);
      @(negedge clk);
      en = e;
      s.m_ready = mr;
      fifo_empty = fifo_q.size() == 0;
      data_out = fifo_empty ? 32'h0 : fifo_q[0];
      #2;
      if (r_ready && fifo_q.size() > 0) begin
         exp_q.push_back('{fifo_q[0], (n_pop % PKT_LEN) == PKT_LEN - 1});
         void'(fifo_q.pop_front());
         n_pop++;
         n_rr++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_rst = 1;
      #3 reset = 0;
      #1;
      chk("rst_r_ready", {31'b0, r_ready}, 0);
      chk("rst_m_valid", {31'b0, s.m_valid}, 0);
      chk("rst_m_data", s.m_data, 0);
      chk("rst_m_last", {31'b0, s.m_last}, 0);
      chk("rst_tx_count", tx_count, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      fifo_q.delete();
      exp_q.delete();
      n_pop = 0;
      n_del = 0;
      stalled = 0;
      repeat (2) @(negedge clk);
      fifo_empty = 1;
      data_out = 0;
      reset = 1;
      in_rst = 0;
   endtask

   // monitor: occupancy model, handshake scoreboard and stall stability
   initial forever begin
      @(negedge clk);
      #1;
      if (!in_rst) begin
         int occ;
         occ = n_pop - n_del;
         chk("r_ready", {31'b0, r_ready}, {31'b0, en & ~fifo_empty & (occ < 2)});
         chk("m_valid", {31'b0, s.m_valid}, {31'b0, occ != 0});
         chk("busy", {31'b0, busy}, {31'b0, occ != 0});
         chk("tx_count", tx_count, n_del);
         if (stalled) begin
            chk("stall_data", s.m_data, prev_data);
            chk("stall_last", {31'b0, s.m_last}, {31'b0, prev_last});
         end
         if (s.m_valid && s.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bubble actual=%h required=none at %0t", s.m_data, $time);
            end else begin
               exp_t x;
               x = exp_q.pop_front();
               chk("m_data", s.m_data, x.d);
               chk("m_last", {31'b0, s.m_last}, {31'b0, x.l});
            end
            n_del++;
         end
         stalled = s.m_valid & ~s.m_ready;
         prev_data = s.m_data;
         prev_last = s.m_last;
      end
   end

   initial begin
      reset = 1;
      en = 0;
      s.m_ready = 0;
      fifo_empty = 1;
      data_out = 0;
      do_reset();
      repeat (10) step(1, 1);
      do_reset();
      fifo_q = '{32'd1, 32'd2, 32'd3};
      n_rr = 0;
      repeat (8) step(1, 1);
      chk("pre_pops", n_rr, 3);
      chk("pre_tx", tx_count, 3);
      do_reset();
      for (int i = 0; i < 8; i++) fifo_q.push_back(32'h10 + i);
      repeat (12) step(1, 1);
      chk("pkt_tx", tx_count, 8);
      do_reset();
      for (int i = 0; i < 5; i++) fifo_q.push_back(32'h10 + i);
      n_rr = 0;
      repeat (6) step(1, 0);
      chk("bp_pops", n_rr, 2);
      chk("bp_head", s.m_data, 32'h10);
      chk("bp_r_ready", {31'b0, r_ready}, 0);
      repeat (10) step(1, 1);
      chk("bp_tx", tx_count, 5);
      do_reset();
      for (int i = 0; i < 4; i++) fifo_q.push_back(32'h20 + i);
      repeat (2) step(1, 0);
      n_rr = 0;
      repeat (5) step(0, 1);
      chk("en_off_pops", n_rr, 0);
      chk("en_off_tx", tx_count, 2);
      repeat (6) step(1, 1);
      chk("en_on_tx", tx_count, 4);
      do_reset();
      for (int i = 0; i < 6; i++) fifo_q.push_back(32'h30 + i);
      repeat (4) step(1, 0);
      chk("mid_full", {31'b0, s.m_valid & ~r_ready}, 1);
      do_reset();
      for (int i = 0; i < 4; i++) fifo_q.push_back(32'h40 + i);
      repeat (8) step(1, 1);
      chk("post_rst_tx", tx_count, 4);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back($urandom);
         step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 60 && (exp_q.size() > 0 || fifo_q.size() > 0); i++) step(1, 1);
      step(1, 1);
      chk("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
